// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and frame helpers for the keyboard display path.
package ps2_pkg;

  localparam int FRAME_LEN = 11;
  localparam int CNT_W     = 4;

  localparam logic FRAME_START = 1'b0;
  localparam logic FRAME_STOP  = 1'b1;

  // Key-release prefix, consumed by the downstream decoder stage.
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  typedef logic [7:0]           scan_code_t;
  typedef logic [FRAME_LEN-2:0] frame_bits_t;

  // bits[0] = start, bits[8:1] = byte, bits[9] = parity; stop_bit is the live sample.
  function automatic logic frame_valid(input frame_bits_t bits, input logic stop_bit);
    return (bits[0] == FRAME_START) && (stop_bit == FRAME_STOP) && (^bits[9:1]);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Scan-code handshake between the PS/2 receiver FIFO and its consumer.
interface ps2_rx_fifo_if;
  import ps2_pkg::*;

  scan_code_t data;
  logic       ready;
  logic       nextdata_n;

  modport master (output data, output ready, input nextdata_n);
  modport slave  (input data, input ready, output nextdata_n);
endinterface

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; push while full is accepted only alongside a pop.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  scan_code_t din,
  input  logic       pop,
  output scan_code_t dout,
  output logic       empty,
  output logic       full
);

  logic [PTR_W:0] w_ptr;
  logic [PTR_W:0] r_ptr;
  scan_code_t     mem [DEPTH];
  logic           do_pop;
  logic           do_push;

  assign empty   = (w_ptr == r_ptr);
  assign full    = (w_ptr[PTR_W] != r_ptr[PTR_W]) &&
                   (w_ptr[PTR_W-1:0] == r_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[r_ptr[PTR_W-1:0]];

  // NOTE: the memory sits inside the reset branch on purpose so data reads 8'h00
  // after reset; this costs a reset net on every entry instead of a plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[w_ptr[PTR_W-1:0]] <= din;
        w_ptr                 <= w_ptr + 1'b1;
      end
      if (do_pop) r_ptr <= r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 pin synchronizer, 11-bit deframer with timeout, and scan-code FIFO front end.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int PTR_W       = 3,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.master bus,
  output logic          overflow,
  output logic          frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             fall;
  logic             sample;

  logic [CNT_W-1:0] cnt;
  frame_bits_t      bits;
  logic [TO_W-1:0]  tcnt;

  logic             push_q;
  logic             err_q;
  scan_code_t       byte_q;
  logic             empty;
  logic             full;

  // clk_sync[1] is the synchronized level, clk_sync[2] its one-cycle history.
  assign fall   = clk_sync[2] && !clk_sync[1];
  assign sample = data_sync[1];

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      bits   <= '0;
      tcnt   <= '0;
      push_q <= 1'b0;
      err_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      push_q <= 1'b0;
      err_q  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (cnt == CNT_W'(FRAME_LEN - 1)) begin
          cnt    <= '0;
          byte_q <= bits[8:1];
          if (frame_valid(bits, sample)) push_q <= 1'b1;
          else                           err_q  <= 1'b1;
        end else begin
          bits[cnt] <= sample;
          cnt       <= cnt + 1'b1;
        end
      end else if (tcnt == TO_W'(TIMEOUT_CYC)) begin
        // Stalled mid-frame: drop the partial frame silently.
        cnt  <= '0;
        tcnt <= '0;
      end else if (cnt != '0) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Full implies non-empty, so a low nextdata_n here is a real pop freeing a slot.
  always_ff @(posedge clk) begin
    if (rst)                                     overflow <= 1'b0;
    else if (push_q && full && bus.nextdata_n)   overflow <= 1'b1;
  end

  assign frame_err = err_q;
  assign bus.ready = !empty;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (byte_q),
    .pop   (!bus.nextdata_n),
    .dout  (bus.data),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames, popped bytes checked by a monitor.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int TO   = 300;
  localparam int HALF = 20;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic overflow;
  logic frame_err;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(
    .FIFO_DEPTH  (8),
    .PTR_W       (3),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .bus       (bus.master),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int         checks     = 0;
  int         failures   = 0;
  int         err_cycles = 0;
  scan_code_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cycles++;
    if (!rst && bus.ready === 1'b1 && bus.nextdata_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h, want no pop", bus.data);
      end else begin
        check("pop_data", {24'b0, bus.data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    step(HALF);
    ps2_clk = 1'b0;
    step(HALF);
    ps2_clk = 1'b1;
  endtask

  // watch: check ready 4 cycles after the last falling edge;
  // pop_at_push: pop exactly in the push cycle of this frame.
  task automatic send_frame(input scan_code_t b, input bit bad_par = 1'b0,
                            input bit watch = 1'b0, input bit pop_at_push = 1'b0);
    logic [10:0] f;
    f = {FRAME_STOP, (~^b) ^ bad_par, b, FRAME_START};
    for (int i = 0; i < FRAME_LEN - 1; i++) send_bit(f[i]);
    ps2_data = f[10];
    step(HALF);
    ps2_clk = 1'b0;
    if (watch) begin
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk);
        #1;
        if (pop_at_push && c == 3) bus.nextdata_n = 1'b0;
        if (pop_at_push && c == 4) bus.nextdata_n = 1'b1;
      end
      check("latency_ready", {31'b0, bus.ready}, 32'd1);
      step(HALF - 4);
    end else begin
      step(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic pop1();
    bus.nextdata_n = 1'b0;
    step(1);
    bus.nextdata_n = 1'b1;
    step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},      {24'b0, bus.data},   32'h00);
    check({tag, "_ready"},     {31'b0, bus.ready},  32'd0);
    check({tag, "_overflow"},  {31'b0, overflow},   32'd0);
    check({tag, "_frame_err"}, {31'b0, frame_err},  32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    bus.nextdata_n = 1'b1;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(5);

    // Single frame with latency check.
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("single_data", {24'b0, bus.data}, 32'h1C);
    pop1();
    check("single_ready_after_pop", {31'b0, bus.ready}, 32'd0);
    check("single_no_err", err_cycles, 32'd0);

    // Pop request while empty is ignored.
    pop1();
    check("empty_pop_ready", {31'b0, bus.ready}, 32'd0);

    // Break sequence.
    exp_q.push_back(BREAK_CODE);
    exp_q.push_back(8'h1C);
    send_frame(BREAK_CODE);
    send_frame(8'h1C);
    check("break_ready", {31'b0, bus.ready}, 32'd1);
    check("break_head", {24'b0, bus.data}, 32'hF0);
    pop1();
    check("break_second", {24'b0, bus.data}, 32'h1C);
    pop1();
    check("break_drained", {31'b0, bus.ready}, 32'd0);

    // Parity fault, then a good frame.
    e0 = err_cycles;
    send_frame(8'h1C, 1'b1);
    check("parity_err_cycles", err_cycles - e0, 32'd1);
    check("parity_no_push", {31'b0, bus.ready}, 32'd0);
    exp_q.push_back(8'h32);
    send_frame(8'h32);
    check("after_parity_data", {24'b0, bus.data}, 32'h32);
    pop1();

    // Overflow: nine frames into eight slots.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(scan_code_t'(i));
      send_frame(scan_code_t'(i));
      if (i == 8) check("full_no_overflow", {31'b0, overflow}, 32'd0);
    end
    check("overflow_set", {31'b0, overflow}, 32'd1);
    check("overflow_head", {24'b0, bus.data}, 32'h01);
    for (int i = 0; i < 8; i++) pop1();
    check("overflow_drained", {31'b0, bus.ready}, 32'd0);
    check("overflow_sticky", {31'b0, overflow}, 32'd1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    check("overflow_cleared", {31'b0, overflow}, 32'd0);

    // Full plus simultaneous pop: the ninth byte is accepted.
    for (int i = 1; i <= 9; i++) exp_q.push_back(scan_code_t'(i));
    for (int i = 1; i <= 8; i++) send_frame(scan_code_t'(i));
    send_frame(8'h09, 1'b0, 1'b1, 1'b1);
    check("full_pop_overflow", {31'b0, overflow}, 32'd0);
    check("full_pop_head", {24'b0, bus.data}, 32'h02);
    for (int i = 0; i < 8; i++) pop1();
    check("full_pop_drained", {31'b0, bus.ready}, 32'd0);

    // Timeout discards a partial frame.
    e0 = err_cycles;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    step(TO + 10);
    exp_q.push_back(8'h32);
    send_frame(8'h32);
    check("timeout_ready", {31'b0, bus.ready}, 32'd1);
    check("timeout_data", {24'b0, bus.data}, 32'h32);
    check("timeout_no_err", err_cycles - e0, 32'd0);
    pop1();

    // Reset mid-frame with a byte still queued.
    send_frame(8'h77);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    step(2);
    check_reset_outputs("midreset");
    rst = 1'b0;
    step(2);
    exp_q.push_back(8'h55);
    send_frame(8'h55);
    check("post_reset_data", {24'b0, bus.data}, 32'h55);
    pop1();
    check("post_reset_drained", {31'b0, bus.ready}, 32'd0);

    check("total_err_cycles", err_cycles, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
